writeback_stage: RTL and testbench

Final RV32I pipeline stage. It accepts retiring instructions from the memory stage and selects the result. It formats load data returned by data memory and drives the register-file write port of the decode stage (i_rd_addr/i_rd_data/i_wr_en on decode). It stalls the pipeline while a load response is outstanding and flags misaligned/illegal loads and bus timeouts.

---
 rtl/writeback_stage_if.sv | 51 +++++
 rtl/writeback_stage.sv | 222 ++++++++++++++++++++++
 tb/tb_writeback_stage.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_stage_if.sv
// Writeback stage bus: memory-stage retire inputs, data-memory read
// response, and the register-file write port / status flags.
//   slave  : writeback_stage side (consumes i_*, drives o_*)
//   master : upstream / environment side (drives i_*, observes o_*)
//   o_instret exists only when WB_RETIRE_CNT_EN is defined.
interface writeback_stage_if #(
    parameter int XLEN  = 32,
    parameter int XADDR = 5
);
    logic             i_valid;
    logic [6:0]       i_opcode;
    logic [2:0]       i_funct3;
    logic [XADDR-1:0] i_rd_addr;
    logic [XLEN-1:0]  i_alu_result;
    logic [XLEN-1:0]  i_imm;
    logic [XLEN-1:0]  i_pc;
    logic             i_dmem_ack;
    logic [XLEN-1:0]  i_dmem_rdata;
    logic [XADDR-1:0] o_rd_addr;
    logic [XLEN-1:0]  o_rd_data;
    logic             o_wr_en;
    logic             o_stall;
    logic             o_misaligned;
    logic             o_illegal;
    logic             o_bus_err;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0]      o_instret;
`endif

    modport slave (
        input  i_valid, i_opcode, i_funct3, i_rd_addr,
        input  i_alu_result, i_imm, i_pc,
        input  i_dmem_ack, i_dmem_rdata,
        output o_rd_addr, o_rd_data, o_wr_en, o_stall,
        output o_misaligned, o_illegal, o_bus_err
`ifdef WB_RETIRE_CNT_EN
        , output o_instret
`endif
    );

    modport master (
        output i_valid, i_opcode, i_funct3, i_rd_addr,
        output i_alu_result, i_imm, i_pc,
        output i_dmem_ack, i_dmem_rdata,
        input  o_rd_addr, o_rd_data, o_wr_en, o_stall,
        input  o_misaligned, o_illegal, o_bus_err
`ifdef WB_RETIRE_CNT_EN
        , input o_instret
`endif
    );
endinterface

// File: rtl/writeback_stage.sv
// RV32I writeback stage: result select, load formatting, load-wait FSM
// with timeout, and registered register-file write port.
// Ports: i_clk, i_rst_n (sync, active-low), bus (writeback_stage_if.slave).
// Optional: define WB_RETIRE_CNT_EN to add the 64-bit o_instret counter.
module writeback_stage #(
    parameter int XLEN    = 32,
    parameter int XADDR   = 5,
    parameter int TIMEOUT = 15
) (
    input logic              i_clk,
    input logic              i_rst_n,
    writeback_stage_if.slave bus
);
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_L     = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_R     = 7'b0110011;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic {IDLE, WAIT} state_e;

    state_e           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [XADDR-1:0] rd_cap_q, rd_cap_d;
    logic [2:0]       f3_cap_q, f3_cap_d;
    logic [1:0]       off_cap_q, off_cap_d;
    logic [XADDR-1:0] rd_addr_q, rd_addr_d;
    logic [XLEN-1:0]  rd_data_q, rd_data_d;
    logic             wr_en_q, wr_en_d;
    logic             mis_q, mis_d;
    logic             ill_q, ill_d;
    logic             berr_q, berr_d;
    logic             stall_c;
    logic             do_wr;
    logic [XADDR-1:0] wr_rd;
    logic [XLEN-1:0]  wr_val;

    logic is_lui, is_alu, is_jmp, is_nowr, is_load;
    logic [1:0] off;
    logic ld_legal, ld_mis;

    function automatic logic [XLEN-1:0] fmt_load(
        input logic [XLEN-1:0] w,
        input logic [2:0]      f3,
        input logic [1:0]      o
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{o, 3'b000} +: 8];
        h = o[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  fmt_load = {{(XLEN-8){b[7]}}, b};
            3'b001:  fmt_load = {{(XLEN-16){h[15]}}, h};
            3'b100:  fmt_load = {{(XLEN-8){1'b0}}, b};
            3'b101:  fmt_load = {{(XLEN-16){1'b0}}, h};
            default: fmt_load = w;
        endcase
    endfunction

    assign is_lui  = bus.i_opcode == OP_LUI;
    assign is_alu  = bus.i_opcode == OP_AUIPC ||
                     bus.i_opcode == OP_R ||
                     bus.i_opcode == OP_I;
    assign is_jmp  = bus.i_opcode == OP_JAL ||
                     bus.i_opcode == OP_JALR;
    assign is_nowr = bus.i_opcode == OP_S ||
                     bus.i_opcode == OP_B;
    assign is_load = bus.i_opcode == OP_L;

    assign off = bus.i_alu_result[1:0];

    assign ld_legal = bus.i_funct3 == 3'b000 ||
                      bus.i_funct3 == 3'b001 ||
                      bus.i_funct3 == 3'b010 ||
                      bus.i_funct3 == 3'b100 ||
                      bus.i_funct3 == 3'b101;

    // Halfwords must be 2-byte aligned, words 4-byte aligned.
    assign ld_mis = (bus.i_funct3[1:0] == 2'b01 && off[0]) ||
                    (bus.i_funct3 == 3'b010 && off != 2'b00);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_cap_d  = rd_cap_q;
        f3_cap_d  = f3_cap_q;
        off_cap_d = off_cap_q;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        wr_en_d   = 1'b0;
        mis_d     = 1'b0;
        ill_d     = 1'b0;
        berr_d    = 1'b0;
        stall_c   = 1'b0;
        do_wr     = 1'b0;
        wr_rd     = bus.i_rd_addr;
        wr_val    = '0;
        case (state_q)
            IDLE: begin
                if (bus.i_valid) begin
                    unique case (1'b1)
                        is_lui: begin
                            do_wr  = 1'b1;
                            wr_val = bus.i_imm;
                        end
                        is_alu: begin
                            do_wr  = 1'b1;
                            wr_val = bus.i_alu_result;
                        end
                        is_jmp: begin
                            do_wr  = 1'b1;
                            wr_val = bus.i_pc + XLEN'(4);
                        end
                        is_load: begin
                            if (!ld_legal) begin
                                ill_d = 1'b1;
                            end else if (ld_mis) begin
                                mis_d = 1'b1;
                            end else if (bus.i_dmem_ack) begin
                                do_wr  = 1'b1;
                                wr_val = fmt_load(bus.i_dmem_rdata,
                                                  bus.i_funct3, off);
                            end else begin
                                rd_cap_d  = bus.i_rd_addr;
                                f3_cap_d  = bus.i_funct3;
                                off_cap_d = off;
                                cnt_d     = '0;
                                state_d   = WAIT;
                                stall_c   = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            WAIT: begin
                wr_rd = rd_cap_q;
                if (bus.i_dmem_ack) begin
                    do_wr   = 1'b1;
                    wr_val  = fmt_load(bus.i_dmem_rdata,
                                       f3_cap_q, off_cap_q);
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    berr_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                    stall_c = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (do_wr) begin
            rd_addr_d = wr_rd;
            rd_data_d = wr_val;
            wr_en_d   = |wr_rd;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rd_cap_q  <= '0;
            f3_cap_q  <= '0;
            off_cap_q <= '0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
            wr_en_q   <= 1'b0;
            mis_q     <= 1'b0;
            ill_q     <= 1'b0;
            berr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_cap_q  <= rd_cap_d;
            f3_cap_q  <= f3_cap_d;
            off_cap_q <= off_cap_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
            wr_en_q   <= wr_en_d;
            mis_q     <= mis_d;
            ill_q     <= ill_d;
            berr_q    <= berr_d;
        end
    end

    assign bus.o_rd_addr    = rd_addr_q;
    assign bus.o_rd_data    = rd_data_q;
    assign bus.o_wr_en      = wr_en_q;
    assign bus.o_misaligned = mis_q;
    assign bus.o_illegal    = ill_q;
    assign bus.o_bus_err    = berr_q;
    assign bus.o_stall      = i_rst_n & stall_c;

`ifdef WB_RETIRE_CNT_EN
    // Normal completion: any write (incl. rd=0) or a store/branch.
    logic        retire_c;
    logic [63:0] instret_q;

    assign retire_c = do_wr ||
                      (state_q == IDLE && bus.i_valid && is_nowr);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_q + {63'b0, retire_c};
        end
    end

    assign bus.o_instret = instret_q;
`endif
endmodule

// File: tb/tb_writeback_stage.sv
// Testbench for writeback_stage: table-driven single-cycle vectors plus
// directed load-wait, reset-in-wait, timeout and ack-at-timeout sequences.
module tb_writeback_stage;
    localparam logic [6:0] LUI  = 7'b0110111;
    localparam logic [6:0] AUI  = 7'b0010111;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;
    localparam logic [6:0] LD   = 7'b0000011;
    localparam logic [6:0] ST   = 7'b0100011;
    localparam logic [6:0] IOP  = 7'b0010011;
    localparam logic [6:0] ROP  = 7'b0110011;
    localparam logic [31:0] W   = 32'h80FF7F01;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_tot = 0;
    logic [63:0] exp_ret = 0;

    always #5 clk = ~clk;

    writeback_stage_if #(.XLEN(32), .XADDR(5)) bus ();

    writeback_stage #(.XLEN(32), .XADDR(5), .TIMEOUT(15)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        ack;
        logic        e_wr;
        logic [31:0] e_data;
        logic        chk;
        logic        e_mis;
        logic        e_ill;
        logic        e_ret;
    } vec_t;

    vec_t vt[18];

    function automatic vec_t mk(
        logic [6:0] op, logic [2:0] f3, logic [4:0] rd,
        logic [31:0] alu, logic [31:0] imm, logic [31:0] pc,
        logic ack, logic e_wr, logic [31:0] e_data, logic chk,
        logic e_mis, logic e_ill, logic e_ret
    );
        vec_t v;
        v.op = op; v.f3 = f3; v.rd = rd;
        v.alu = alu; v.imm = imm; v.pc = pc; v.ack = ack;
        v.e_wr = e_wr; v.e_data = e_data; v.chk = chk;
        v.e_mis = e_mis; v.e_ill = e_ill; v.e_ret = e_ret;
        return v;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_tot++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic chk_ret(string nm);
`ifdef WB_RETIRE_CNT_EN
        chk(nm, bus.o_instret, exp_ret);
`else
        if (nm.len() == 0) $display("empty");
`endif
    endtask

    task automatic idle_in();
        bus.i_valid = 1'b0;
        bus.i_opcode = 7'd0;
        bus.i_funct3 = 3'd0;
        bus.i_rd_addr = 5'd0;
        bus.i_alu_result = 32'd0;
        bus.i_imm = 32'd0;
        bus.i_pc = 32'd0;
        bus.i_dmem_ack = 1'b0;
        bus.i_dmem_rdata = W;
    endtask

    task automatic load(logic [2:0] f3, logic [4:0] rd,
                        logic [31:0] a, logic ack);
        bus.i_valid = 1'b1;
        bus.i_opcode = LD;
        bus.i_funct3 = f3;
        bus.i_rd_addr = rd;
        bus.i_alu_result = a;
        bus.i_dmem_ack = ack;
    endtask

    task automatic apply(int i, vec_t v);
        string s;
        s = $sformatf("v%0d", i);
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_opcode = v.op;
        bus.i_funct3 = v.f3;
        bus.i_rd_addr = v.rd;
        bus.i_alu_result = v.alu;
        bus.i_imm = v.imm;
        bus.i_pc = v.pc;
        bus.i_dmem_ack = v.ack;
        bus.i_dmem_rdata = W;
        #1;
        chk({s, "_stall"}, bus.o_stall, 1'b0);
        @(posedge clk);
        #1;
        idle_in();
        chk({s, "_wr"}, bus.o_wr_en, v.e_wr);
        chk({s, "_mis"}, bus.o_misaligned, v.e_mis);
        chk({s, "_ill"}, bus.o_illegal, v.e_ill);
        if (v.chk) begin
            chk({s, "_rd"}, bus.o_rd_addr, v.rd);
            chk({s, "_data"}, bus.o_rd_data, v.e_data);
        end
        if (v.e_ret) exp_ret++;
        chk_ret({s, "_ret"});
    endtask

    initial begin
        int stalls;
        int at;
        logic wrote;
        vt[0]  = mk(LUI, 0, 5, 0, 32'h12345000, 0, 0,
                    1, 32'h12345000, 1, 0, 0, 1);
        vt[1]  = mk(JAL, 0, 1, 0, 0, 32'h100, 0,
                    1, 32'h104, 1, 0, 0, 1);
        vt[2]  = mk(JAL, 0, 0, 0, 0, 32'h200, 0,
                    0, 32'h204, 1, 0, 0, 1);
        vt[3]  = mk(LD, 3'b000, 3, 32'h1003, 0, 0, 1,
                    1, 32'hFFFFFF80, 1, 0, 0, 1);
        vt[4]  = mk(LD, 3'b100, 3, 32'h1003, 0, 0, 1,
                    1, 32'h00000080, 1, 0, 0, 1);
        vt[5]  = mk(LD, 3'b001, 3, 32'h1002, 0, 0, 1,
                    1, 32'hFFFF80FF, 1, 0, 0, 1);
        vt[6]  = mk(LD, 3'b101, 8, 32'h1000, 0, 0, 1,
                    1, 32'h00007F01, 1, 0, 0, 1);
        vt[7]  = mk(LD, 3'b010, 10, 32'h1000, 0, 0, 1,
                    1, 32'h80FF7F01, 1, 0, 0, 1);
        vt[8]  = mk(LD, 3'b000, 11, 32'h1001, 0, 0, 1,
                    1, 32'h0000007F, 1, 0, 0, 1);
        vt[9]  = mk(AUI, 0, 7, 32'hDEAD0000, 0, 0, 0,
                    1, 32'hDEAD0000, 1, 0, 0, 1);
        vt[10] = mk(ROP, 0, 31, 32'h1, 0, 0, 0,
                    1, 32'h1, 1, 0, 0, 1);
        vt[11] = mk(JALR, 0, 2, 0, 0, 32'hFFFFFFFC, 0,
                    1, 32'h0, 1, 0, 0, 1);
        vt[12] = mk(LD, 3'b010, 12, 32'h2002, 0, 0, 0,
                    0, 0, 0, 1, 0, 0);
        vt[13] = mk(LD, 3'b001, 12, 32'h2001, 0, 0, 0,
                    0, 0, 0, 1, 0, 0);
        vt[14] = mk(LD, 3'b011, 12, 32'h2000, 0, 0, 0,
                    0, 0, 0, 0, 1, 0);
        vt[15] = mk(ST, 3'b010, 0, 32'h40, 0, 0, 0,
                    0, 0, 0, 0, 0, 1);
        vt[16] = mk(IOP, 0, 0, 32'h55, 0, 0, 0,
                    0, 32'h55, 1, 0, 0, 1);
        vt[17] = mk(LD, 3'b110, 12, 32'h2000, 0, 0, 0,
                    0, 0, 0, 0, 1, 0);

        idle_in();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", bus.o_stall, 1'b0);
        chk("rst_wr", bus.o_wr_en, 1'b0);
        chk("rst_rd", bus.o_rd_addr, 5'd0);
        chk("rst_data", bus.o_rd_data, 32'd0);
        chk("rst_flags", {bus.o_misaligned, bus.o_illegal,
                          bus.o_bus_err}, 3'b000);
        chk_ret("rst_ret");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) apply(i, vt[i]);

        // LW held by upstream, ack arrives 3 cycles after accept.
        stalls = 0;
        @(negedge clk);
        load(3'b010, 9, 32'h2000, 1'b0);
        #1;
        if (bus.o_stall) stalls++;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            if (bus.o_stall) stalls++;
            chk("wait_wr", bus.o_wr_en, 1'b0);
        end
        @(negedge clk);
        bus.i_dmem_ack = 1'b1;
        bus.i_dmem_rdata = 32'hCAFEF00D;
        #1;
        chk("wait_stalls", stalls, 3);
        chk("ack_stall", bus.o_stall, 1'b0);
        @(posedge clk);
        #1;
        idle_in();
        chk("ack_wr", bus.o_wr_en, 1'b1);
        chk("ack_rd", bus.o_rd_addr, 5'd9);
        chk("ack_data", bus.o_rd_data, 32'hCAFEF00D);
        exp_ret++;
        chk_ret("ack_ret");
        @(posedge clk);
        #1;
        chk("ack_pulse", bus.o_wr_en, 1'b0);

        // Reset while waiting abandons the load.
        @(negedge clk);
        load(3'b010, 13, 32'h2004, 1'b0);
        @(posedge clk);
        #1;
        idle_in();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstw_stall", bus.o_stall, 1'b0);
        @(posedge clk);
        #1;
        exp_ret = 0;
        chk("rstw_wr", bus.o_wr_en, 1'b0);
        chk("rstw_rd", bus.o_rd_addr, 5'd0);
        chk_ret("rstw_ret");
        @(negedge clk);
        rst_n = 1'b1;
        bus.i_dmem_ack = 1'b1;
        #1;
        chk("stray_stall", bus.o_stall, 1'b0);
        @(posedge clk);
        #1;
        bus.i_dmem_ack = 1'b0;
        chk("stray_wr", bus.o_wr_en, 1'b0);
        apply(100, vt[0]);

        // No ack: bus error after 15 wait cycles.
        @(negedge clk);
        load(3'b010, 4, 32'h3000, 1'b0);
        @(posedge clk);
        #1;
        idle_in();
        at = 0;
        wrote = 1'b0;
        for (int k = 1; k <= 40 && at == 0; k++) begin
            @(posedge clk);
            #1;
            if (bus.o_wr_en) wrote = 1'b1;
            if (bus.o_bus_err) at = k;
        end
        chk("to_cycle", at, 15);
        chk("to_nowr", wrote, 1'b0);
        chk_ret("to_ret");
        @(posedge clk);
        #1;
        chk("to_pulse", bus.o_bus_err, 1'b0);

        // Ack in the final wait cycle wins over the timeout.
        @(negedge clk);
        load(3'b000, 6, 32'h3006, 1'b0);
        @(posedge clk);
        #1;
        idle_in();
        repeat (14) @(posedge clk);
        @(negedge clk);
        bus.i_dmem_ack = 1'b1;
        bus.i_dmem_rdata = 32'h01C34567;
        #1;
        chk("tack_stall", bus.o_stall, 1'b0);
        @(posedge clk);
        #1;
        idle_in();
        chk("tack_berr", bus.o_bus_err, 1'b0);
        chk("tack_wr", bus.o_wr_en, 1'b1);
        chk("tack_data", bus.o_rd_data, 32'hFFFFFFC3);
        exp_ret++;
        chk_ret("tack_ret");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
